// File: rtl/datapath_pkg.sv
// Shared ALU opcode encoding and default sizing for the datapath pipe.
package datapath_pkg;

    localparam int DP_WIDTH = 8;
    localparam int DP_NREGS = 8;

    typedef enum logic [2:0] {
        ULA_ADD = 3'b000,
        ULA_SUB = 3'b001,
        ULA_AND = 3'b010,
        ULA_OR  = 3'b011,
        ULA_XOR = 3'b100,
        ULA_SLT = 3'b101,
        ULA_SLL = 3'b110,
        ULA_SRL = 3'b111
    } ula_op_t;

endpackage

// File: rtl/datapath_pipe_if.sv
// Request/result bundle of the datapath pipe; master drives ops and
// external writes, slave is the pipe itself.
interface datapath_pipe_if import datapath_pkg::*; #(
    parameter int WIDTH = DP_WIDTH,
    parameter int NREGS = DP_NREGS
);
    localparam int AW = $clog2(NREGS);

    logic             we3;
    logic [AW-1:0]    wa3;
    logic [WIDTH-1:0] wd3;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ula_control;
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic             select_src;
    logic [WIDTH-1:0] constante;
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] ULAResult;
    logic             out_valid;
    logic             Z, N, C, V;

    modport master (
        output we3, wa3, wd3, in_valid, ula_control, ra1, ra2, select_src,
               constante, wb_en, wb_addr,
        input  in_ready, ULAResult, out_valid, Z, N, C, V
    );

    modport slave (
        input  we3, wa3, wd3, in_valid, ula_control, ra1, ra2, select_src,
               constante, wb_en, wb_addr,
        output in_ready, ULAResult, out_valid, Z, N, C, V
    );

endinterface

// File: rtl/ula_param.sv
// Combinational WIDTH-parametrised ALU producing result and Z/N/C/V.
module ula_param import datapath_pkg::*; #(
    parameter int WIDTH = DP_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  ula_op_t          op,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH:0] sum, diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            ULA_ADD: begin
                y = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            ULA_SUB: begin
                // C is "no borrow": set when a >= b unsigned
                y = diff[WIDTH-1:0];
                c = ~diff[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            ULA_AND: y = a & b;
            ULA_OR:  y = a | b;
            ULA_XOR: y = a ^ b;
            ULA_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ULA_SLL: y = a << b[SW-1:0];
            ULA_SRL: y = a >> b[SW-1:0];
            default: y = '0;
        endcase
    end

    assign z = (y == '0);
    assign n = y[WIDTH-1];

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage register-file + ALU pipe. Define DATAPATH_FWD_EN to forward the
// executing result to a dependent op instead of stalling it one cycle.
module datapath_pipe import datapath_pkg::*; #(
    parameter int WIDTH = DP_WIDTH,
    parameter int NREGS = DP_NREGS
) (
    input  logic           clk,
    input  logic           rst,
    datapath_pipe_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0][WIDTH-1:0] regs;
    logic [1:0]                  vld_pipe;
    logic [WIDTH-1:0]            r_a, r_b;
    ula_op_t                     r_op;
    logic                        r_wb_en;
    logic [AW-1:0]               r_wb_addr;
    logic [WIDTH-1:0]            rd_a, rd_b, op_a, op_b;
    logic [WIDTH-1:0]            alu_y;
    logic                        alu_z, alu_n, alu_c, alu_v;
    logic [WIDTH-1:0]            res_q;
    logic [3:0]                  flg_q;
    logic                        accept, wb_fire;

    assign rd_a    = regs[bus.ra1];
    assign rd_b    = regs[bus.ra2];
    assign wb_fire = vld_pipe[0] && r_wb_en;

`ifdef DATAPATH_FWD_EN
    logic fwd_a, fwd_b;
    assign fwd_a = wb_fire && (r_wb_addr == bus.ra1);
    assign fwd_b = wb_fire && (r_wb_addr == bus.ra2);
    assign op_a  = fwd_a ? alu_y : rd_a;
    assign op_b  = bus.select_src ? bus.constante : (fwd_b ? alu_y : rd_b);
    assign bus.in_ready = rst;
`else
    // The executing op writes back on the next edge, so one wait cycle lets
    // the dependent op read the fresh value straight from the array.
    logic hazard;
    assign hazard = bus.in_valid && wb_fire &&
                    ((r_wb_addr == bus.ra1) ||
                     (!bus.select_src && (r_wb_addr == bus.ra2)));
    assign op_a  = rd_a;
    assign op_b  = bus.select_src ? bus.constante : rd_b;
    assign bus.in_ready = rst && !hazard;
`endif

    assign accept = bus.in_valid && bus.in_ready;

    ula_param #(.WIDTH(WIDTH)) u_ula (
        .a  (r_a),
        .b  (r_b),
        .op (r_op),
        .y  (alu_y),
        .z  (alu_z),
        .n  (alu_n),
        .c  (alu_c),
        .v  (alu_v)
    );

    // Write-back is last so it wins over an external write to the same address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else begin
            if (bus.we3) regs[bus.wa3] <= bus.wd3;
            if (wb_fire) regs[r_wb_addr] <= alu_y;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= ULA_ADD;
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], accept};
            if (accept) begin
                r_a       <= op_a;
                r_b       <= op_b;
                r_op      <= ula_op_t'(bus.ula_control);
                r_wb_en   <= bus.wb_en;
                r_wb_addr <= bus.wb_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q <= '0;
            flg_q <= '0;
        end else if (vld_pipe[0]) begin
            res_q <= alu_y;
            flg_q <= {alu_z, alu_n, alu_c, alu_v};
        end
    end

    assign bus.ULAResult = res_q;
    assign bus.out_valid = vld_pipe[1];
    assign bus.Z         = flg_q[3];
    assign bus.N         = flg_q[2];
    assign bus.C         = flg_q[1];
    assign bus.V         = flg_q[0];

endmodule
